// File: rtl/pipe_pc_ctrl.sv
// pipe_pc_ctrl: fetch-PC selection and stall/bubble hazard control for a five-stage Y86-64 pipeline
//   params : RESET_PC            fetch address after reset
//   inputs : clk, rst (sync, active-high), f_/D_/E_/M_/W_ icodes, f_valC, f_valP,
//            d_srcA, d_srcB, E_dstM, e_cnd, M_cnd, M_valA, W_valM, m_stat, W_stat
//   outputs: f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted,
//            stall_cnt, mispred_cnt (built only with PC_CTRL_STATS_EN, else constant 0)
module pipe_pc_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  W_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_dstM,
  input  logic        e_cnd,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [63:0] W_valM,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic [63:0] f_pc,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [31:0] mispred_cnt
);
  localparam logic [3:0] JXX = 4'h7, CALL = 4'h8, RET = 4'h9, MRMOVQ = 4'h5, POPQ = 4'hB, RNONE = 4'hF;
  localparam logic [2:0] AOK = 3'd1;
  typedef enum logic [1:0] {RUN, DRAIN, HALT} st_t;
  st_t st, st_nx;
  logic [63:0] pred_pc, hold_pc;
  logic loaduse, retp, mispred;
  assign loaduse = (E_icode == MRMOVQ || E_icode == POPQ) && E_dstM != RNONE &&
                   (E_dstM == d_srcA || E_dstM == d_srcB);
  assign retp    = D_icode == RET || E_icode == RET || M_icode == RET;
  assign mispred = E_icode == JXX && !e_cnd;
  // hold_pc keeps the last live fetch address so f_pc stays frozen once halted
  assign f_pc = st == HALT ? hold_pc :
                (M_icode == JXX && !M_cnd) ? M_valA :
                W_icode == RET ? W_valM : pred_pc;
  always_comb begin
    st_nx    = st;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    halted   = 1'b0;
    if (!rst && st == HALT) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
      halted  = 1'b1;
    end else if (!rst) begin
      F_stall  = loaduse || retp;
      D_stall  = loaduse;
      D_bubble = mispred || (retp && !loaduse);
      E_bubble = mispred || loaduse;
      M_bubble = st == DRAIN || m_stat != AOK || W_stat != AOK;
      st_nx    = W_stat != AOK ? HALT : m_stat != AOK ? DRAIN : st;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= RUN;
      pred_pc <= RESET_PC;
      hold_pc <= RESET_PC;
    end else begin
      st <= st_nx;
      if (!F_stall) pred_pc <= (f_icode == JXX || f_icode == CALL) ? f_valC : f_valP;
      if (st != HALT) hold_pc <= f_pc;
    end
  end
`ifdef PC_CTRL_STATS_EN
  logic [31:0] s_cnt, m_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_cnt <= '0;
      m_cnt <= '0;
    end else begin
      if (F_stall && st != HALT && s_cnt != '1) s_cnt <= s_cnt + 32'd1;
      if (mispred && m_cnt != '1) m_cnt <= m_cnt + 32'd1;
    end
  end
  assign stall_cnt   = s_cnt;
  assign mispred_cnt = m_cnt;
`else
  assign stall_cnt   = '0;
  assign mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// tb_pipe_pc_ctrl: randomized and directed check of pipe_pc_ctrl against a behavioural model
module tb_pipe_pc_ctrl;
  logic        clk = 1'b0, rst;
  logic [3:0]  f_icode, D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM;
  logic [63:0] f_valC, f_valP, M_valA, W_valM, f_pc;
  logic        e_cnd, M_cnd;
  logic [2:0]  m_stat, W_stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [31:0] stall_cnt, mispred_cnt;
  int n_chk = 0, n_pass = 0;
  logic [63:0] m_pred, m_hold;
  logic        m_halt, m_drain;
  logic [31:0] m_sc, m_mc;
  logic [6:0]  ctl;

  pipe_pc_ctrl #(.RESET_PC(64'h100)) dut (
    .clk(clk), .rst(rst), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_cnd(M_cnd),
    .M_valA(M_valA), .W_valM(W_valM), .m_stat(m_stat), .W_stat(W_stat), .f_pc(f_pc),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .halted(halted),
    .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    rst = 1'b0; f_icode = 4'h1; D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1; M_cnd = 1'b1;
    f_valC = 64'h0; M_valA = 64'h0; W_valM = 64'h0; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  // one clock: compare at negedge with the model, advance the model, return just after posedge
  task automatic cyc();
    logic lu, rp, mp;
    logic [6:0] ec;
    logic [63:0] ep;
    @(negedge clk);
    lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF && (E_dstM == d_srcA || E_dstM == d_srcB);
    rp = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    mp = E_icode == 4'h7 && !e_cnd;
    if (rst) ec = 7'b0;
    else if (m_halt) ec = 7'b1100011;
    else ec = {lu | rp, lu, mp | (rp & !lu), mp | lu, m_drain | (m_stat != 3'd1) | (W_stat != 3'd1), 2'b00};
    ep = m_halt ? m_hold : (M_icode == 4'h7 && !M_cnd) ? M_valA : W_icode == 4'h9 ? W_valM : m_pred;
    chk("ctl", {57'b0, ctl}, {57'b0, ec});
    if (!rst) chk("f_pc", f_pc, ep);
`ifdef PC_CTRL_STATS_EN
    chk("stall_cnt", {32'b0, stall_cnt}, {32'b0, m_sc});
    chk("mispred_cnt", {32'b0, mispred_cnt}, {32'b0, m_mc});
`else
    chk("stats_off", {stall_cnt, mispred_cnt}, 64'h0);
`endif
    if (rst) begin
      m_pred = 64'h100; m_hold = 64'h100; m_halt = 1'b0; m_drain = 1'b0; m_sc = 0; m_mc = 0;
    end else begin
      if (!ec[6]) m_pred = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valC : f_valP;
      if (mp) m_mc = m_mc + 1;
      if (!m_halt) begin
        m_hold = ep;
        if (ec[6]) m_sc = m_sc + 1;
        if (W_stat != 3'd1) m_halt = 1'b1;
        else if (m_stat != 3'd1) m_drain = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_pred = 0; m_hold = 0; m_halt = 0; m_drain = 0; m_sc = 0; m_mc = 0;
    idle(); rst = 1'b1; f_valP = 64'h0;
    @(posedge clk); #1;
    cyc();
    rst = 1'b0; f_valP = 64'h10A; #1;
    chk("pc0", f_pc, 64'h100); chk("idle_ctl", {57'b0, ctl}, 64'h0);
    cyc(); f_valP = 64'h114; #1; chk("pc1", f_pc, 64'h10A);
    cyc(); f_valP = 64'h11E; #1; chk("pc2", f_pc, 64'h114);
    cyc();
    f_icode = 4'h7; f_valC = 64'h200; cyc(); f_icode = 4'h1; f_valP = 64'h208;
    E_icode = 4'h7; e_cnd = 1'b0; #1;
    chk("mp_bub", {62'b0, D_bubble, E_bubble}, 64'h3);
    cyc(); E_icode = 4'h1; e_cnd = 1'b1; M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h123; #1;
    chk("mp_pc", f_pc, 64'h123);
    cyc(); M_icode = 4'h1; M_cnd = 1'b1;
    D_icode = 4'h9; #1; chk("ret_d", {62'b0, F_stall, D_bubble}, 64'h3);
    cyc(); D_icode = 4'h1; E_icode = 4'h9; cyc(); E_icode = 4'h1; M_icode = 4'h9; #1;
    chk("ret_m", {62'b0, F_stall, D_bubble}, 64'h3);
    cyc(); M_icode = 4'h1; W_icode = 4'h9; W_valM = 64'h340; #1;
    chk("ret_pc", f_pc, 64'h340); chk("ret_w_ctl", {63'b0, F_stall}, 64'h0);
    cyc(); W_icode = 4'h1;
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    chk("lu", {61'b0, F_stall, D_stall, E_bubble}, 64'h7);
    cyc(); D_icode = 4'h9; #1;
    chk("lu_ret", {62'b0, D_stall, D_bubble}, 64'h2);
    cyc(); idle(); cyc();
    m_stat = 3'd3; #1; chk("adr_mb", {63'b0, M_bubble}, 64'h1);
    cyc(); m_stat = 3'd1; W_stat = 3'd3; #1; chk("drain_mb", {63'b0, M_bubble}, 64'h1);
    cyc(); W_stat = 3'd1; f_valP = 64'h999; #1;
    chk("halt", {62'b0, halted, W_stall}, 64'h3);
    cyc(); cyc(); chk("halt_hold", {63'b0, halted}, 64'h1);
    rst = 1'b1; cyc(); idle(); #1; chk("rst_pc", f_pc, 64'h100);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 39) == 0;
      f_icode = 4'($urandom_range(0, 11)); D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11)); M_icode = 4'($urandom_range(0, 11));
      W_icode = 4'($urandom_range(0, 11));
      d_srcA = 4'($urandom_range(0, 15)); d_srcB = 4'($urandom_range(0, 15));
      E_dstM = 4'($urandom_range(0, 15));
      e_cnd = 1'($urandom); M_cnd = 1'($urandom);
      f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
      M_valA = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      m_stat = $urandom_range(0, 49) == 0 ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat = $urandom_range(0, 79) == 0 ? 3'($urandom_range(2, 4)) : 3'd1;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
